// File: rtl/decode_queue.sv
// decode_queue: instruction buffer plus RISC-V field decoder.
// (PC, instruction) pairs are accepted over a valid/ready handshake into a
// DEPTH-entry FIFO. The head entry is decoded and loaded into a registered
// output stage that has its own valid/ready handshake.
//
// Ports:
//   Clock, Reset        rising-edge clock, asynchronous active-high reset
//   In_Valid/In_Ready   input handshake; In_Ready depends only on Count/Reset
//   PC, Instruction     input pair
//   Flush               synchronous discard of FIFO contents and Out_Valid
//   Out_Valid/Out_Ready output handshake
//   Out_PC, Control, Read_Register_1/2, Write_Register, Funct3, Funct7,
//   Imm, Illegal        registered decode of the head instruction
//   Count               FIFO occupancy, not counting the output register
module decode_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic [XLEN-1:0]          PC,
    input  logic [XLEN-1:0]          Instruction,
    input  logic                     Flush,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic [XLEN-1:0]          Out_PC,
    output logic [6:0]               Control,
    output logic [4:0]               Read_Register_1,
    output logic [4:0]               Read_Register_2,
    output logic [4:0]               Write_Register,
    output logic [2:0]               Funct3,
    output logic [6:0]               Funct7,
    output logic [XLEN-1:0]          Imm,
    output logic                     Illegal,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [31:0]     ins_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            load;
    logic [31:0]     head_ins;
    logic [31:0]     head_imm;
    logic            head_ill;

    // Full FIFO refuses input even if the head is popped this cycle.
    assign In_Ready = (Count < CW'(DEPTH)) && !Reset;
    assign push     = In_Valid && In_Ready && !Flush;
    assign load     = (Count != '0) && (!Out_Valid || Out_Ready) && !Flush;
    assign head_ins = ins_mem[rd_ptr];

    // Immediate generation and legality check for the FIFO head.
    always_comb begin
        head_imm = '0;
        head_ill = 1'b0;
        case (head_ins[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                head_imm = {{20{head_ins[31]}}, head_ins[31:20]};
            OP_STORE:
                head_imm = {{20{head_ins[31]}}, head_ins[31:25], head_ins[11:7]};
            OP_BRANCH:
                head_imm = {{19{head_ins[31]}}, head_ins[31], head_ins[7],
                            head_ins[30:25], head_ins[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                head_imm = {head_ins[31:12], 12'b0};
            OP_JAL:
                head_imm = {{11{head_ins[31]}}, head_ins[31], head_ins[19:12],
                            head_ins[20], head_ins[30:21], 1'b0};
            OP_OP, OP_SYSTEM, OP_FENCE:
                head_imm = '0;
            default:
                head_ill = 1'b1;
        endcase
        if (head_ins[1:0] != 2'b11) begin
            head_ill = 1'b1;
            head_imm = '0;
        end
    end

    // FIFO storage; contents need no reset since Count gates every read.
    always_ff @(posedge Clock) begin
        if (push) begin
            pc_mem[wr_ptr]  <= PC;
            ins_mem[wr_ptr] <= Instruction[31:0];
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (load) rd_ptr <= rd_ptr + PW'(1);
            Count <= Count + CW'(push) - CW'(load);
        end
    end

    // Output stage; data fields only move on a load, so Flush leaves them.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Out_Valid       <= 1'b0;
            Out_PC          <= '0;
            Control         <= '0;
            Read_Register_1 <= '0;
            Read_Register_2 <= '0;
            Write_Register  <= '0;
            Funct3          <= '0;
            Funct7          <= '0;
            Imm             <= '0;
            Illegal         <= 1'b0;
        end else if (Flush) begin
            Out_Valid <= 1'b0;
        end else if (load) begin
            Out_Valid       <= 1'b1;
            Out_PC          <= pc_mem[rd_ptr];
            Control         <= head_ins[6:0];
            Read_Register_1 <= head_ins[19:15];
            Read_Register_2 <= head_ins[24:20];
            Write_Register  <= head_ins[11:7];
            Funct3          <= head_ins[14:12];
            Funct7          <= head_ins[31:25];
            Imm             <= XLEN'($signed(head_imm));
            Illegal         <= head_ill;
        end else if (Out_Ready) begin
            Out_Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: accepted inputs are queued with the
// expected decode, and a monitor compares every output handshake in order.
module tb_decode_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     pc;
    logic [31:0]     instr;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_pc;
    logic [6:0]      control;
    logic [4:0]      rr1;
    logic [4:0]      rr2;
    logic [4:0]      wr;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [31:0]     imm;
    logic            ill;
    logic [CW-1:0]   count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } txn_t;

    txn_t exp_q[$];
    txn_t e;
    int   checks = 0;
    int   passes = 0;
    int   mc = 0;
    int   mov = 0;
    bit   m_acc;
    bit   m_ld;
    bit   hold_prev = 1'b0;
    logic [31:0] s_pc, s_imm;
    logic [32:0] s_fields;
    int   acc_cnt;

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .Clock(clk), .Reset(rst), .In_Valid(in_valid), .In_Ready(in_ready),
        .PC(pc), .Instruction(instr), .Flush(flush), .Out_Valid(out_valid),
        .Out_Ready(out_ready), .Out_PC(out_pc), .Control(control),
        .Read_Register_1(rr1), .Read_Register_2(rr2), .Write_Register(wr),
        .Funct3(f3), .Funct7(f7), .Imm(imm), .Illegal(ill), .Count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference immediate, assembled from shifted bit groups.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int signed s;
        s = $signed(i);
        case (i[6:0])
            7'h03, 7'h13, 7'h67: return 32'(s >>> 20);
            7'h23: return (32'(s >>> 25) << 5) | 32'(i[11:7]);
            7'h63: return (32'(s >>> 31) << 12) | (32'(i[7]) << 11)
                        | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            7'h37, 7'h17: return i & 32'hFFFF_F000;
            7'h6F: return (32'(s >>> 31) << 20) | (32'(i[19:12]) << 12)
                        | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_ill(input logic [31:0] i);
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
            7'h6F, 7'h33, 7'h73, 7'h0F: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [6:0]  ops [12] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37,
                                  7'h17, 7'h6F, 7'h33, 7'h73, 7'h0F, 7'h00};
        logic [31:0] r;
        int unsigned k;
        r = $urandom;
        k = $urandom_range(0, 12);
        if (k < 12) r[6:0] = ops[k];
        return r;
    endfunction

    // Reference occupancy model plus scoreboard push on accepted input.
    always @(negedge clk) begin
        if (rst) begin
            mc = 0;
            mov = 0;
            exp_q.delete();
        end else begin
            chk("count", 64'(count), 64'(mc));
            chk("out_valid", 64'(out_valid), 64'(mov));
            chk("in_ready", 64'(in_ready), 64'(mc < int'(DEPTH)));
            if (flush) begin
                mc = 0;
                mov = 0;
                exp_q.delete();
            end else begin
                m_acc = in_valid && (mc < int'(DEPTH));
                m_ld  = (mc > 0) && (mov == 0 || out_ready);
                if (m_acc) exp_q.push_back('{pc, instr});
                mc = mc + int'(m_acc) - int'(m_ld);
                if (m_ld) mov = 1;
                else if (out_ready) mov = 0;
            end
        end
    end

    // Monitor: compare each consumed output and stability under stall.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_pc", 64'(out_pc), 64'(s_pc));
                chk("stall_imm", 64'(imm), 64'(s_imm));
                chk("stall_fields", 64'({control, rr1, rr2, wr, f3, f7, ill}), 64'(s_fields));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got pc 0x%0h, expected no output", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", 64'(out_pc), 64'(e.pc));
                    chk("control", 64'(control), 64'(e.ins[6:0]));
                    chk("rs1", 64'(rr1), 64'(e.ins[19:15]));
                    chk("rs2", 64'(rr2), 64'(e.ins[24:20]));
                    chk("rd", 64'(wr), 64'(e.ins[11:7]));
                    chk("funct3", 64'(f3), 64'(e.ins[14:12]));
                    chk("funct7", 64'(f7), 64'(e.ins[31:25]));
                    chk("imm", 64'(imm), 64'(ref_imm(e.ins)));
                    chk("illegal", 64'(ill), 64'(ref_ill(e.ins)));
                end
            end
            hold_prev = out_valid && !out_ready && !flush;
            s_pc = out_pc;
            s_imm = imm;
            s_fields = {control, rr1, rr2, wr, f3, f7, ill};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] i);
        in_valid = v;
        pc = p;
        instr = i;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_out_pc", 64'(out_pc), 64'(0));
        chk("rst_illegal", 64'(ill), 64'(0));
        rst = 1'b0;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'(1));

        // addi x1,x2,5 into an empty queue
        out_ready = 1'b1;
        drive(1'b1, 32'h100, 32'h0051_0093);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("addi_valid", 64'(out_valid), 64'(1));
        chk("addi_pc", 64'(out_pc), 64'(32'h100));
        chk("addi_ctrl", 64'(control), 64'(7'h13));
        chk("addi_rd", 64'(wr), 64'(1));
        chk("addi_rs1", 64'(rr1), 64'(2));
        chk("addi_f3", 64'(f3), 64'(0));
        chk("addi_imm", 64'(imm), 64'(5));
        chk("addi_ill", 64'(ill), 64'(0));
        repeat (2) tick();

        // Three back-to-back instructions, one emerging per cycle
        drive(1'b1, 32'h200, 32'hFE51_2E23);
        tick();
        drive(1'b1, 32'h204, 32'h1234_51B7);
        tick();
        chk("sw_imm", 64'(imm), 64'(32'hFFFF_FFFC));
        chk("sw_rs2", 64'(rr2), 64'(5));
        drive(1'b1, 32'h208, 32'h0);
        tick();
        chk("lui_imm", 64'(imm), 64'(32'h1234_5000));
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("zero_ill", 64'(ill), 64'(1));
        chk("zero_imm", 64'(imm), 64'(0));
        chk("zero_pc", 64'(out_pc), 64'(32'h208));
        repeat (2) tick();

        // Back-pressure: DEPTH+2 offered, DEPTH+1 accepted
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int k = 0; k < int'(DEPTH) + 2; k++) begin
            drive(1'b1, 32'h300 + 32'(4 * k), rnd_instr());
            acc_cnt += int'(in_ready);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0);
        chk("bp_accepted", 64'(acc_cnt), 64'(DEPTH + 1));
        chk("bp_count", 64'(count), 64'(DEPTH));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_head_pc", 64'(out_pc), 64'(32'h300));
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (DEPTH + 3) tick();
        chk("bp_drained", 64'(count), 64'(0));

        // Flush with two queued while a new input is offered
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h400 + 32'(4 * k), 32'h0051_0093);
            tick();
        end
        chk("pre_flush_count", 64'(count), 64'(2));
        flush = 1'b1;
        drive(1'b1, 32'h4F0, 32'h1234_51B7);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        repeat (3) tick();
        chk("post_flush_valid", 64'(out_valid), 64'(0));

        // Steady push/pop at Count = 2 across pointer wrap
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h500 + 32'(4 * k), rnd_instr());
            tick();
        end
        out_ready = 1'b1;
        for (int k = 3; k < 13; k++) begin
            drive(1'b1, 32'h500 + 32'(4 * k), rnd_instr());
            tick();
            chk("steady_count", 64'(count), 64'(2));
        end
        drive(1'b0, 32'h0, 32'h0);
        repeat (DEPTH + 2) tick();

        // Randomised traffic with occasional flushes
        for (int k = 0; k < 400; k++) begin
            flush = ($urandom_range(0, 31) == 0);
            drive(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, rnd_instr());
            out_ready = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
            tick();
        end
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        repeat (DEPTH + 3) tick();

        // Asynchronous reset between edges with three entries queued
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h600 + 32'(4 * k), 32'h0051_0093);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0);
        chk("pre_rst_count", 64'(count), 64'(3));
        #2;
        rst = 1'b1;
        #1;
        chk("async_count", 64'(count), 64'(0));
        chk("async_valid", 64'(out_valid), 64'(0));
        chk("async_imm", 64'(imm), 64'(0));
        chk("async_in_ready", 64'(in_ready), 64'(0));
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
